// File: rtl/data_sram_resp_pkg.sv
// Shared definitions for the data SRAM request bus between EX and the responder.
// The field order of dsram_req_t is the wire order EX drives.
package data_sram_resp_pkg;

   localparam int unsigned DSRAM_DEPTH_DEFAULT = 1024;
   localparam logic [63:0] DSRAM_BASE_DEFAULT  = 64'h0000_0000_8000_0000;
   localparam int unsigned STALL_MEM_BIT       = 3;
   localparam int unsigned DSRAM_REQ_W         = 1 + 1 + 8 + 64 + 64;

   typedef struct packed {
      logic        en;
      logic        we;
      logic [7:0]  sel;
      logic [63:0] addr;
      logic [63:0] wdata;
   } dsram_req_t;

   typedef enum logic {
      INIT,
      READY
   } dsram_state_t;

endpackage

// File: rtl/data_sram_resp_bytewe_array.sv
// DEPTHx64 storage split into eight byte lanes, each with its own write enable
// and a registered synchronous read port.
module dsram_bytewe_array #(
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned AW    = 10
) (
   input  logic          clk,
   input  logic          we,
   input  logic [7:0]    be,
   input  logic [AW-1:0] waddr,
   input  logic [63:0]   wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [63:0]   rdata
);

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_lane
         logic [7:0] mem [DEPTH];
         logic [7:0] rd_reg;

         always_ff @(posedge clk) begin
            if (we && be[gi]) begin
               mem[waddr] <= wdata[8*gi +: 8];
            end
            if (re) begin
               rd_reg <= mem[raddr];
            end
         end

         assign rdata[8*gi +: 8] = rd_reg;
      end
   endgenerate

endmodule

// File: rtl/data_sram_resp.sv
// Data SRAM responder: post-reset clear sequencer, range check, stall gating,
// byte-masked stores, 1-cycle loads and sticky out-of-range error capture.
module data_sram_resp
   import data_sram_resp_pkg::*;
#(
   parameter int unsigned DEPTH = DSRAM_DEPTH_DEFAULT,
   parameter int unsigned AW    = 10,
   parameter logic [63:0] BASE  = DSRAM_BASE_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  stall,
   input  logic        data_sram_en,
   input  logic        data_sram_we,
   input  logic [7:0]  data_sram_sel,
   input  logic [63:0] data_sram_addr,
   input  logic [63:0] data_sram_wdata,
   output logic [63:0] data_sram_rdata,
   output logic        stall_req,
   output logic        err,
   output logic [63:0] err_addr
);

   localparam logic [63:0] LIMIT = BASE + 64'(DEPTH) * 64'd8;

   dsram_req_t   req;
   dsram_state_t state_reg, state_next;
   logic [AW-1:0] cnt_reg, cnt_next;
   logic          rd_zero_reg, rd_zero_next;
   logic          err_reg, err_next;
   logic [63:0]   err_addr_reg, err_addr_next;
   logic          in_range, accept;
   logic          arr_we, arr_re;
   logic [7:0]    arr_be;
   logic [AW-1:0] arr_waddr, idx;
   logic [63:0]   arr_wdata, arr_rdata;
   logic [5:0]    unused_stall;

   assign req          = {data_sram_en, data_sram_we, data_sram_sel, data_sram_addr, data_sram_wdata};
   assign unused_stall = stall;
   assign idx          = req.addr[AW+2:3];
   assign in_range     = (req.addr >= BASE) && (req.addr < LIMIT);
   assign accept       = req.en && !stall[STALL_MEM_BIT];

   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      rd_zero_next  = rd_zero_reg;
      err_next      = err_reg;
      err_addr_next = err_addr_reg;
      arr_we        = 1'b0;
      arr_re        = 1'b0;
      arr_be        = 8'h00;
      arr_waddr     = idx;
      arr_wdata     = req.wdata;
      case (state_reg)
         INIT: begin
            arr_we    = 1'b1;
            arr_be    = 8'hFF;
            arr_waddr = cnt_reg;
            arr_wdata = 64'd0;
            cnt_next  = cnt_reg + 1'b1;
            if (cnt_reg == AW'(DEPTH - 1)) begin
               state_next = READY;
            end
         end
         READY: begin
            if (accept) begin
               if (in_range) begin
                  if (req.we) begin
                     arr_we = 1'b1;
                     arr_be = req.sel;
                  end else begin
                     arr_re       = 1'b1;
                     rd_zero_next = 1'b0;
                  end
               end else begin
                  // Out-of-range loads return zero instead of stale data.
                  if (!req.we) begin
                     rd_zero_next = 1'b1;
                  end
                  if (!err_reg) begin
                     err_next      = 1'b1;
                     err_addr_next = req.addr;
                  end
               end
            end
         end
         default: state_next = INIT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= INIT;
         cnt_reg      <= '0;
         rd_zero_reg  <= 1'b1;
         err_reg      <= 1'b0;
         err_addr_reg <= 64'd0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         rd_zero_reg  <= rd_zero_next;
         err_reg      <= err_next;
         err_addr_reg <= err_addr_next;
      end
   end

   dsram_bytewe_array #(
      .DEPTH(DEPTH),
      .AW   (AW)
   ) u_array (
      .clk  (clk),
      .we   (arr_we),
      .be   (arr_be),
      .waddr(arr_waddr),
      .wdata(arr_wdata),
      .re   (arr_re),
      .raddr(idx),
      .rdata(arr_rdata)
   );

   // The read register itself has no reset; rd_zero_reg masks it after reset.
   assign data_sram_rdata = rd_zero_reg ? 64'd0 : arr_rdata;
   assign stall_req       = (state_reg == INIT);
   assign err             = err_reg;
   assign err_addr        = err_addr_reg;

endmodule

// File: tb/tb_data_sram_resp.sv
// Scoreboard bench for data_sram_resp with DEPTH=16: expected load data is
// queued when a request is driven and compared one cycle later.
module tb_data_sram_resp;
   import data_sram_resp_pkg::*;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned AW    = 4;
   localparam logic [63:0] BASE  = DSRAM_BASE_DEFAULT;
   localparam logic [63:0] LIMIT = BASE + 64'(DEPTH * 8);

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [5:0]  stall = 6'd0;
   logic        data_sram_en = 1'b0;
   logic        data_sram_we = 1'b0;
   logic [7:0]  data_sram_sel = 8'h00;
   logic [63:0] data_sram_addr = 64'd0;
   logic [63:0] data_sram_wdata = 64'd0;
   logic [63:0] data_sram_rdata;
   logic        stall_req;
   logic        err;
   logic [63:0] err_addr;

   int          errors = 0;
   int          checks = 0;
   logic [63:0] exp_q [$];
   logic [63:0] model_mem [DEPTH];
   logic [63:0] model_rdata;
   logic        model_err;
   logic [63:0] model_err_addr;

   always #5 clk = ~clk;

   data_sram_resp #(
      .DEPTH(DEPTH),
      .AW   (AW),
      .BASE (BASE)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .stall          (stall),
      .data_sram_en   (data_sram_en),
      .data_sram_we   (data_sram_we),
      .data_sram_sel  (data_sram_sel),
      .data_sram_addr (data_sram_addr),
      .data_sram_wdata(data_sram_wdata),
      .data_sram_rdata(data_sram_rdata),
      .stall_req      (stall_req),
      .err            (err),
      .err_addr       (err_addr)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 64'd0;
      model_rdata    = 64'd0;
      model_err      = 1'b0;
      model_err_addr = 64'd0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_rdata"}, data_sram_rdata, 64'd0);
      check({tag, "_stall_req"}, {63'd0, stall_req}, 64'd1);
      check({tag, "_err"}, {63'd0, err}, 64'd0);
      check({tag, "_err_addr"}, err_addr, 64'd0);
   endtask

   // Counts INIT cycles while driving requests that must all be ignored.
   task automatic wait_init(input string tag);
      int n = 0;
      while (stall_req && n < 100) begin
         data_sram_en    = 1'b1;
         data_sram_we    = n[0];
         data_sram_sel   = 8'hFF;
         data_sram_addr  = n[0] ? (BASE + 64'h78) : (BASE - 64'h8);
         data_sram_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
         @(posedge clk);
         #1;
         n++;
      end
      data_sram_en = 1'b0;
      check({tag, "_init_len"}, 64'(n), 64'(DEPTH));
      check({tag, "_init_err"}, {63'd0, err}, 64'd0);
      check({tag, "_init_rdata"}, data_sram_rdata, 64'd0);
      $display("init %s: stall_req high for %0d cycles", tag, n);
   endtask

   task automatic req(input string tag, input logic w, input logic [7:0] s,
                      input logic [63:0] a, input logic [63:0] d, input logic stl);
      logic [AW-1:0] idx;
      data_sram_en    = 1'b1;
      data_sram_we    = w;
      data_sram_sel   = s;
      data_sram_addr  = a;
      data_sram_wdata = d;
      stall[STALL_MEM_BIT] = stl;
      if (!stl) begin
         if (a >= BASE && a < LIMIT) begin
            idx = a[AW+2:3];
            if (w) begin
               for (int i = 0; i < 8; i++)
                  if (s[i]) model_mem[idx][8*i +: 8] = d[8*i +: 8];
            end else begin
               model_rdata = model_mem[idx];
            end
         end else begin
            if (!w) model_rdata = 64'd0;
            if (!model_err) begin
               model_err      = 1'b1;
               model_err_addr = a;
            end
         end
      end
      if (!w) exp_q.push_back(model_rdata);
      @(posedge clk);
      #1;
      data_sram_en = 1'b0;
      stall[STALL_MEM_BIT] = 1'b0;
      if (!w) check({tag, "_rdata"}, data_sram_rdata, exp_q.pop_front());
      check({tag, "_err"}, {63'd0, err}, {63'd0, model_err});
      check({tag, "_err_addr"}, err_addr, model_err_addr);
      check({tag, "_stall_req"}, {63'd0, stall_req}, 64'd0);
      $display("txn %s: %s sel=%h addr=%h wdata=%h stall=%0b rdata=%h err=%0b",
               tag, w ? "ST" : "LD", s, a, d, stl, data_sram_rdata, err);
   endtask

   initial begin
      logic [63:0] v;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("por");
      rst_n = 1'b1;
      wait_init("por");

      req("ld_top", 1'b0, 8'hFF, BASE + 64'h78, 64'd0, 1'b0);

      req("st_full", 1'b1, 8'hFF, BASE + 64'h10, 64'h1122_3344_5566_7788, 1'b0);
      req("st_lane1", 1'b1, 8'h02, BASE + 64'h10, 64'h0000_0000_0000_AA00, 1'b0);
      req("ld_merge", 1'b0, 8'hFF, BASE + 64'h10, 64'd0, 1'b0);
      check("merge_const", data_sram_rdata, 64'h1122_3344_5566_AA88);

      req("ld_stalled", 1'b0, 8'hFF, BASE + 64'h78, 64'd0, 1'b1);
      req("st_stalled", 1'b1, 8'hFF, BASE + 64'h10, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1);
      req("st_sel0", 1'b1, 8'h00, BASE + 64'h10, 64'hCAFE_CAFE_CAFE_CAFE, 1'b0);
      req("ld_after_stall", 1'b0, 8'h00, BASE + 64'h10, 64'd0, 1'b0);

      req("st_below", 1'b1, 8'hFF, BASE - 64'h8, 64'h1234, 1'b0);
      req("ld_above", 1'b0, 8'hFF, LIMIT, 64'd0, 1'b0);
      check("err_addr_const", err_addr, BASE - 64'h8);
      req("st_last", 1'b1, 8'hF0, LIMIT - 64'h8, 64'h5555_6666_7777_8888, 1'b0);
      req("ld_last", 1'b0, 8'hFF, LIMIT - 64'h8, 64'd0, 1'b0);
      req("ld_above2", 1'b0, 8'hFF, LIMIT + 64'h100, 64'd0, 1'b0);

      for (int i = 0; i < 8; i++) begin
         v = {$urandom, $urandom};
         req($sformatf("alt_st%0d", i), 1'b1, 8'hFF, BASE + 64'h20, v, 1'b0);
         req($sformatf("alt_ld%0d", i), 1'b0, 8'hFF, BASE + 64'h20, 64'd0, 1'b0);
      end

      // Reset in the middle of INIT.
      rst_n = 1'b0;
      #2;
      check_reset_vals("rst_ready1");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      repeat (6) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_reset_vals("rst_init");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      wait_init("reinit1");

      req("pre_st_a", 1'b1, 8'hFF, BASE + 64'h30, 64'h0102_0304_0506_0708, 1'b0);
      req("pre_st_b", 1'b1, 8'hFF, BASE + 64'h38, 64'hA1A2_A3A4_A5A6_A7A8, 1'b0);
      req("pre_ld_b", 1'b0, 8'hFF, BASE + 64'h38, 64'd0, 1'b0);
      req("pre_err", 1'b0, 8'hFF, 64'd0, 64'd0, 1'b0);
      req("pre_ld_a", 1'b0, 8'hFF, BASE + 64'h30, 64'd0, 1'b0);

      // Reset in READY, between clock edges.
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_vals("rst_ready2");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      wait_init("reinit2");
      req("post_ld_a", 1'b0, 8'hFF, BASE + 64'h30, 64'd0, 1'b0);
      req("post_ld_b", 1'b0, 8'hFF, BASE + 64'h38, 64'd0, 1'b0);
      req("post_ld_20", 1'b0, 8'hFF, BASE + 64'h20, 64'd0, 1'b0);
      req("post_ld_10", 1'b0, 8'hFF, BASE + 64'h10, 64'd0, 1'b0);

      check("sb_empty", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
